// File: rtl/counter_reg_arbiter_if.sv
// Requester-side bundle for the shared counter register arbiter:
// request/operation/load lines in, grant/status/register value out.
interface counter_reg_arbiter_if #(
  parameter int WIDTH = 4,
  parameter int NREQ  = 2
);
  logic [NREQ-1:0]       req;
  logic [2*NREQ-1:0]     op;
  logic [WIDTH*NREQ-1:0] din;
  logic [NREQ-1:0]       gnt;
  logic                  done;
  logic                  wrap;
  logic                  busy;
  logic [WIDTH-1:0]      cr_data_output;

  modport master (
    output req, op, din,
    input  gnt, done, wrap, busy, cr_data_output
  );

  modport slave (
    input  req, op, din,
    output gnt, done, wrap, busy, cr_data_output
  );
endinterface

// File: rtl/counter_reg_arbiter.sv
// Round-robin arbiter sharing one counter register among NREQ requesters;
// each grant applies one inc/dec/load/clear and releases on a 4-phase handshake.
module counter_reg_arbiter #(
  parameter int WIDTH = 4,
  parameter int NREQ  = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  counter_reg_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, GRANT, EXEC, WAIT_REL} state_t;

  localparam logic [1:0] OP_INC  = 2'b00;
  localparam logic [1:0] OP_DEC  = 2'b01;
  localparam logic [1:0] OP_LOAD = 2'b10;
  localparam logic [1:0] OP_CLR  = 2'b11;

  state_t           state, state_nxt;
  logic [NREQ-1:0]  gnt, gnt_nxt;
  logic             done, done_nxt;
  logic             wrap, wrap_nxt;
  logic [1:0]       ptr, ptr_nxt;
  logic [1:0]       win, win_nxt, win_inc;
  logic [1:0]       pick;
  logic             pick_vld;
  logic             win_req;
  logic [WIDTH-1:0] cnt, cnt_nxt;
  logic [1:0]       cap_op, sel_op;
  logic [WIDTH-1:0] cap_din, sel_din;

  // Returns {wrap, next value}.
  function automatic logic [WIDTH:0] apply_op(input logic [1:0]       o,
                                              input logic [WIDTH-1:0] cur,
                                              input logic [WIDTH-1:0] ld);
    logic [WIDTH:0] r;
    r = '0;
    case (o)
      OP_INC:  r = {cur == '1, cur + WIDTH'(1)};
      OP_DEC:  r = {cur == '0, cur - WIDTH'(1)};
      OP_LOAD: r = {1'b0, ld};
      OP_CLR:  r = '0;
    endcase
    return r;
  endfunction

  // Winner = requester with the smallest upward distance from the pointer.
  always_comb begin
    int best;
    int d;
    best     = NREQ;
    d        = 0;
    pick     = ptr;
    pick_vld = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      d = i - int'(ptr);
      if (d < 0) d = d + NREQ;
      if (bus.req[i] && d < best) begin
        best     = d;
        pick     = 2'(i);
        pick_vld = 1'b1;
      end
    end
  end

  // The held one-hot grant selects the winner's request and operands.
  always_comb begin
    sel_op  = '0;
    sel_din = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt[i]) begin
        sel_op  = bus.op[2*i +: 2];
        sel_din = bus.din[WIDTH*i +: WIDTH];
      end
    end
  end

  assign win_req = |(bus.req & gnt);
  assign win_inc = (win == 2'(NREQ-1)) ? 2'd0 : win + 2'd1;

  always_comb begin
    state_nxt = state;
    gnt_nxt   = gnt;
    done_nxt  = 1'b0;
    wrap_nxt  = 1'b0;
    ptr_nxt   = ptr;
    win_nxt   = win;
    cnt_nxt   = cnt;
    case (state)
      IDLE: begin
        if (pick_vld) begin
          win_nxt   = pick;
          gnt_nxt   = {{(NREQ-1){1'b0}}, 1'b1} << pick;
          state_nxt = GRANT;
        end
      end
      GRANT: begin
        if (!win_req) begin
          gnt_nxt   = '0;
          ptr_nxt   = win_inc;
          state_nxt = IDLE;
        end else begin
          state_nxt = EXEC;
        end
      end
      EXEC: begin
        {wrap_nxt, cnt_nxt} = apply_op(cap_op, cnt, cap_din);
        done_nxt            = 1'b1;
        state_nxt           = WAIT_REL;
      end
      WAIT_REL: begin
        if (!win_req) begin
          gnt_nxt   = '0;
          ptr_nxt   = win_inc;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      gnt   <= '0;
      done  <= 1'b0;
      wrap  <= 1'b0;
      ptr   <= '0;
      win   <= '0;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      gnt   <= gnt_nxt;
      done  <= done_nxt;
      wrap  <= wrap_nxt;
      ptr   <= ptr_nxt;
      win   <= win_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Operand capture needs no reset: only read in EXEC, which always follows GRANT.
  always_ff @(posedge clk) begin
    if (state == GRANT) begin
      cap_op  <= sel_op;
      cap_din <= sel_din;
    end
  end

  assign bus.gnt            = gnt;
  assign bus.done           = done;
  assign bus.wrap           = wrap;
  assign bus.busy           = (state != IDLE);
  assign bus.cr_data_output = cnt;
endmodule

// File: tb/tb_counter_reg_arbiter.sv
// Directed bench for counter_reg_arbiter (WIDTH=4, NREQ=2) with hand-computed expectations.
module tb_counter_reg_arbiter;
  logic clk;
  logic reset;
  int   n_vec;
  int   n_err;

  counter_reg_arbiter_if #(.WIDTH(4), .NREQ(2)) bus ();

  counter_reg_arbiter #(.WIDTH(4), .NREQ(2)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and settle just after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset   = 1'b0;
    bus.req = '0;
    bus.op  = '0;
    bus.din = '0;
    repeat (2) @(posedge clk);
    #1;
    n_vec++; if (bus.gnt !== 2'b00) begin n_err++; $display("FAIL reset_gnt got=%b want=00", bus.gnt); end
    n_vec++; if (bus.done !== 1'b0) begin n_err++; $display("FAIL reset_done got=%b want=0", bus.done); end
    n_vec++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got=%b want=0", bus.busy); end
    n_vec++; if (bus.cr_data_output !== 4'h0) begin n_err++; $display("FAIL reset_cr got=%h want=0", bus.cr_data_output); end
    reset = 1'b1;
  endtask

  task automatic test_load();
    bus.req      = 2'b01;
    bus.op[1:0]  = 2'b10;
    bus.din[3:0] = 4'b1010;
    step();
    n_vec++; if (bus.gnt !== 2'b01) begin n_err++; $display("FAIL load_gnt got=%b want=01", bus.gnt); end
    n_vec++; if (bus.busy !== 1'b1) begin n_err++; $display("FAIL load_busy got=%b want=1", bus.busy); end
    step();
    n_vec++; if (bus.done !== 1'b0) begin n_err++; $display("FAIL load_early_done got=%b want=0", bus.done); end
    step();
    n_vec++; if (bus.done !== 1'b1) begin n_err++; $display("FAIL load_done got=%b want=1", bus.done); end
    n_vec++; if (bus.cr_data_output !== 4'b1010) begin n_err++; $display("FAIL load_cr got=%b want=1010", bus.cr_data_output); end
    n_vec++; if (bus.wrap !== 1'b0) begin n_err++; $display("FAIL load_wrap got=%b want=0", bus.wrap); end
    bus.req = 2'b00;
    step();
    n_vec++; if (bus.gnt !== 2'b00) begin n_err++; $display("FAIL load_release_gnt got=%b want=00", bus.gnt); end
    n_vec++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL load_release_busy got=%b want=0", bus.busy); end
    n_vec++; if (bus.done !== 1'b0) begin n_err++; $display("FAIL load_done_pulse got=%b want=0", bus.done); end
  endtask

  // Pointer is 1 on entry, so req[1] wins the preload.
  task automatic test_wrap();
    bus.req      = 2'b10;
    bus.op[3:2]  = 2'b10;
    bus.din[7:4] = 4'hF;
    repeat (3) step();
    n_vec++; if (bus.cr_data_output !== 4'hF) begin n_err++; $display("FAIL wrap_preload got=%h want=f", bus.cr_data_output); end
    bus.req = 2'b00;
    step();
    bus.req     = 2'b10;
    bus.op[3:2] = 2'b00;
    step();
    n_vec++; if (bus.gnt !== 2'b10) begin n_err++; $display("FAIL wrap_inc_gnt got=%b want=10", bus.gnt); end
    repeat (2) step();
    n_vec++; if (bus.cr_data_output !== 4'h0) begin n_err++; $display("FAIL wrap_inc_cr got=%h want=0", bus.cr_data_output); end
    n_vec++; if (bus.wrap !== 1'b1) begin n_err++; $display("FAIL wrap_inc_flag got=%b want=1", bus.wrap); end
    step();
    n_vec++; if (bus.wrap !== 1'b0) begin n_err++; $display("FAIL wrap_inc_pulse got=%b want=0", bus.wrap); end
    n_vec++; if (bus.gnt !== 2'b10) begin n_err++; $display("FAIL wrap_gnt_held got=%b want=10", bus.gnt); end
    bus.req = 2'b00;
    step();
    bus.req     = 2'b10;
    bus.op[3:2] = 2'b01;
    repeat (3) step();
    n_vec++; if (bus.cr_data_output !== 4'hF) begin n_err++; $display("FAIL wrap_dec_cr got=%h want=f", bus.cr_data_output); end
    n_vec++; if (bus.wrap !== 1'b1) begin n_err++; $display("FAIL wrap_dec_flag got=%b want=1", bus.wrap); end
    bus.req = 2'b00;
    step();
  endtask

  // Both requesters increment; count starts at f so it walks 0,1,2,3.
  task automatic test_round_robin();
    logic [1:0] exp_gnt;
    logic [3:0] exp_cnt;
    bus.op  = 4'b0000;
    bus.req = 2'b11;
    exp_cnt = 4'hF;
    for (int i = 0; i < 4; i++) begin
      exp_gnt = (i % 2 == 0) ? 2'b01 : 2'b10;
      exp_cnt = exp_cnt + 4'd1;
      step();
      n_vec++; if (bus.gnt !== exp_gnt) begin n_err++; $display("FAIL rr_gnt[%0d] got=%b want=%b", i, bus.gnt, exp_gnt); end
      repeat (2) step();
      n_vec++; if (bus.done !== 1'b1) begin n_err++; $display("FAIL rr_done[%0d] got=%b want=1", i, bus.done); end
      n_vec++; if (bus.cr_data_output !== exp_cnt) begin n_err++; $display("FAIL rr_cr[%0d] got=%h want=%h", i, bus.cr_data_output, exp_cnt); end
      bus.req = bus.req & ~exp_gnt;
      step();
      n_vec++; if (bus.gnt !== 2'b00) begin n_err++; $display("FAIL rr_release[%0d] got=%b want=00", i, bus.gnt); end
      bus.req = bus.req | exp_gnt;
    end
    bus.req = 2'b00;
    step();
  endtask

  // Pointer is 0 and count is 3 on entry.
  task automatic test_abort();
    bus.req      = 2'b01;
    bus.op       = 4'b0010;
    bus.din[3:0] = 4'h5;
    step();
    n_vec++; if (bus.gnt !== 2'b01) begin n_err++; $display("FAIL abort_gnt got=%b want=01", bus.gnt); end
    bus.req = 2'b10;
    step();
    n_vec++; if (bus.gnt !== 2'b00) begin n_err++; $display("FAIL abort_gnt_clear got=%b want=00", bus.gnt); end
    n_vec++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL abort_busy got=%b want=0", bus.busy); end
    n_vec++; if (bus.done !== 1'b0) begin n_err++; $display("FAIL abort_done got=%b want=0", bus.done); end
    step();
    n_vec++; if (bus.gnt !== 2'b10) begin n_err++; $display("FAIL abort_next_gnt got=%b want=10", bus.gnt); end
    n_vec++; if (bus.cr_data_output !== 4'h3) begin n_err++; $display("FAIL abort_cr got=%h want=3", bus.cr_data_output); end
    repeat (2) step();
    n_vec++; if (bus.cr_data_output !== 4'h4) begin n_err++; $display("FAIL abort_next_cr got=%h want=4", bus.cr_data_output); end
    bus.req = 2'b00;
    step();
  endtask

  // Pointer is 0 on entry; the reset lands between the EXEC entry edge and the apply edge.
  task automatic test_reset_mid_exec();
    bus.req      = 2'b01;
    bus.op       = 4'b0010;
    bus.din[3:0] = 4'b0111;
    repeat (2) step();
    #2;
    reset = 1'b0;
    #1;
    n_vec++; if (bus.gnt !== 2'b00) begin n_err++; $display("FAIL rst_exec_gnt got=%b want=00", bus.gnt); end
    n_vec++; if (bus.done !== 1'b0) begin n_err++; $display("FAIL rst_exec_done got=%b want=0", bus.done); end
    n_vec++; if (bus.cr_data_output !== 4'h0) begin n_err++; $display("FAIL rst_exec_cr got=%h want=0", bus.cr_data_output); end
    @(negedge clk);
    reset   = 1'b1;
    bus.req = 2'b10;
    step();
    n_vec++; if (bus.gnt !== 2'b10) begin n_err++; $display("FAIL rst_exec_regrant got=%b want=10", bus.gnt); end
    n_vec++; if (bus.cr_data_output !== 4'h0) begin n_err++; $display("FAIL rst_exec_discard got=%h want=0", bus.cr_data_output); end
    repeat (2) step();
    n_vec++; if (bus.cr_data_output !== 4'h1) begin n_err++; $display("FAIL rst_exec_after got=%h want=1", bus.cr_data_output); end
    bus.req = 2'b00;
    step();
  endtask

  // Pointer is 0 on entry; operands change after the capture edge.
  task automatic test_op_change();
    bus.req      = 2'b01;
    bus.op[1:0]  = 2'b10;
    bus.din[3:0] = 4'b0011;
    repeat (2) step();
    bus.op[1:0]  = 2'b11;
    bus.din[3:0] = 4'b0000;
    step();
    n_vec++; if (bus.done !== 1'b1) begin n_err++; $display("FAIL opchg_done got=%b want=1", bus.done); end
    n_vec++; if (bus.cr_data_output !== 4'b0011) begin n_err++; $display("FAIL opchg_cr got=%b want=0011", bus.cr_data_output); end
    bus.req = 2'b00;
    step();
    n_vec++; if (bus.gnt !== 2'b00) begin n_err++; $display("FAIL opchg_release got=%b want=00", bus.gnt); end
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    test_reset();
    test_load();
    test_wrap();
    test_round_robin();
    test_abort();
    test_reset_mid_exec();
    test_op_change();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
